// File: rtl/vic_pkg.sv
// Shared types and helpers for the per-level vectored interrupt controller.
// Holds the FSM encoding, vector width and the flattened-vector accessor.
package vic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int VEC_W = 9;
    localparam int MAX_N = 16;
    localparam int BUS_W = VEC_W * MAX_N;

    // Index width that stays legal for a single-source level.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [VEC_W-1:0] vec_slice(input logic [BUS_W-1:0] bus,
                                                   input int unsigned  i);
        return bus[VEC_W*i +: VEC_W];
    endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// Priority search over the request vector: rotate by start, find first set,
// then map the hit back to an absolute index. Fixed priority ignores start.
module vic_prio_enc
    import vic_pkg::*;
#(
    parameter int N           = 8,
    parameter int ROUND_ROBIN = 0,
    localparam int IDX_W      = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    int unsigned    base;
    int unsigned    first;
    int unsigned    pos;

    always_comb begin
        base = (ROUND_ROBIN != 0) ? 32'(start) : 32'd0;
        if (base >= 32'(N)) begin
            base = 32'd0;
        end
        req_dbl = {req, req};
        req_rot = req_dbl[base +: N];
        valid   = 1'b0;
        first   = 32'd0;
        // Scan downwards so the lowest rotated position wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                valid = 1'b1;
                first = 32'(k);
            end
        end
        pos = first + base;
        if (pos >= 32'(N)) begin
            pos = pos - 32'(N);
        end
        idx = IDX_W'(pos);
    end

endmodule

// File: rtl/vic_level.sv
// Vectored interrupt controller for one bus priority level: collects device
// requests, raises irq_o, answers the vector strobe and pulses dev_iack.
module vic_level
    import vic_pkg::*;
#(
    parameter int N           = 8,
    parameter int ROUND_ROBIN = 0
) (
    input  logic               clk_p,
    input  logic               rst,
    input  logic [N-1:0]       dev_irq,
    input  logic [VEC_W*N-1:0] dev_vec,
    output logic [N-1:0]       dev_iack,
    output logic               irq_o,
    input  logic               istb_i,
    output logic [VEC_W-1:0]   ivec_o,
    output logic               iack_o,
    output logic               busy_o
);

    localparam int IDX_W = idx_w(N);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             take;
    logic             irq_d;
    logic             iack_d;
    logic             busy_d;
    logic [N-1:0]     grant_onehot;
    logic [VEC_W-1:0] grant_vec;

    vic_prio_enc #(
        .N           (N),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_prio_enc (
        .req   (dev_irq),
        .start (rr_ptr_q),
        .valid (grant_valid),
        .idx   (grant_idx)
    );

    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A strobe left high from the last cycle must drop first.
                if (grant_valid && !istb_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!grant_valid) begin
                    state_d = IDLE;
                end else if (istb_i) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!istb_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        take         = (state_q == REQ) && (state_d == ACK);
        irq_d        = (state_d == REQ);
        iack_d       = (state_d == ACK) || (state_d == RELEASE);
        busy_d       = (state_d != IDLE);
        grant_onehot = '0;
        grant_onehot[grant_idx] = 1'b1;
        grant_vec    = vec_slice(BUS_W'(dev_vec), 32'(grant_idx));
    end

    // Outputs are registered from the next-state decode so they line up with state_q.
    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            irq_o    <= 1'b0;
            iack_o   <= 1'b0;
            busy_o   <= 1'b0;
            ivec_o   <= '0;
            dev_iack <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            irq_o    <= irq_d;
            iack_o   <= iack_d;
            busy_o   <= busy_d;
            dev_iack <= take ? grant_onehot : '0;
            if (take) begin
                sel_q  <= grant_idx;
                ivec_o <= grant_vec & ~VEC_W'(3);
            end else if (!iack_d) begin
                ivec_o <= '0;
            end
            if ((state_q == ACK) && (ROUND_ROBIN != 0) && (N > 1)) begin
                rr_ptr_q <= (sel_q == IDX_W'(N - 1)) ? '0 : sel_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vic_level.sv
// Bench for vic_level: one fixed-priority and one round-robin instance,
// directed scenarios plus randomized rounds against a behavioural model.
module tb_vic_level;

    logic        clk_p = 1'b0;
    logic        rst;
    logic [7:0]  irq_a, irq_b, dack_a, dack_b;
    logic [71:0] vec_a, vec_b;
    logic        irqo_a, irqo_b, istb_a, istb_b, iack_a, iack_b, busy_a, busy_b;
    logic [8:0]  ivec_a, ivec_b;
    int          chk = 0;
    int          err = 0;
    int          rr_model = 0;

    always #5 clk_p = ~clk_p;

    vic_level #(.N(8), .ROUND_ROBIN(0)) dut_a (
        .clk_p(clk_p), .rst(rst), .dev_irq(irq_a), .dev_vec(vec_a), .dev_iack(dack_a),
        .irq_o(irqo_a), .istb_i(istb_a), .ivec_o(ivec_a), .iack_o(iack_a), .busy_o(busy_a)
    );

    vic_level #(.N(8), .ROUND_ROBIN(1)) dut_b (
        .clk_p(clk_p), .rst(rst), .dev_irq(irq_b), .dev_vec(vec_b), .dev_iack(dack_b),
        .irq_o(irqo_b), .istb_i(istb_b), .ivec_o(ivec_b), .iack_o(iack_b), .busy_o(busy_b)
    );

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic set_vec(input bit use_b, input int i, input logic [8:0] v);
        if (use_b) vec_b[9*i +: 9] = v;
        else       vec_a[9*i +: 9] = v;
    endtask

    // Behaves like the processor: waits for irq_o (bounded), strobes, releases.
    // With clr set the granted device drops its request on seeing dev_iack.
    task automatic serve(input bit use_b, input int delay, input bit clr,
                         output bit got, output logic [8:0] v, output logic [7:0] d);
        got = 1'b0; v = '0; d = '0;
        for (int c = 0; c < 20; c++) begin
            if ((use_b ? irqo_b : irqo_a) === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) return;
        repeat (delay) tick();
        if (use_b) istb_b = 1'b1; else istb_a = 1'b1;
        tick();
        v = use_b ? ivec_b : ivec_a;
        d = use_b ? dack_b : dack_a;
        if (clr) begin
            if (use_b) irq_b = irq_b & ~d; else irq_a = irq_a & ~d;
        end
        tick();
        if (use_b) istb_b = 1'b0; else istb_a = 1'b0;
        tick();
    endtask

    // Winner: first requesting index at or after start, circularly.
    function automatic int model_win(input logic [7:0] req, input int start);
        for (int o = 0; o < 8; o++) begin
            if (req[(start + o) % 8]) return (start + o) % 8;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        irq_a = '0; irq_b = '0; vec_a = '0; vec_b = '0; istb_a = 1'b0; istb_b = 1'b0;
        repeat (2) tick();
        chk++; if ({irqo_a, iack_a, busy_a, ivec_a, dack_a} !== 20'd0) begin err++; $display("FAIL reset_a: got %h want 0", {irqo_a, iack_a, busy_a, ivec_a, dack_a}); end
        chk++; if ({irqo_b, iack_b, busy_b, ivec_b, dack_b} !== 20'd0) begin err++; $display("FAIL reset_b: got %h want 0", {irqo_b, iack_b, busy_b, ivec_b, dack_b}); end
        rst = 1'b0;
        tick();
        chk++; if ({irqo_a, busy_a} !== 2'b00) begin err++; $display("FAIL idle_no_req: got %b want 00", {irqo_a, busy_a}); end
    endtask

    task automatic test_single();
        set_vec(0, 3, 9'o060);
        irq_a = 8'h08;
        tick();
        chk++; if (irqo_a !== 1'b1) begin err++; $display("FAIL single_irq_lat: got %b want 1", irqo_a); end
        tick(); tick();
        istb_a = 1'b1;
        tick();
        chk++; if (iack_a !== 1'b1) begin err++; $display("FAIL single_iack: got %b want 1", iack_a); end
        chk++; if (ivec_a !== 9'o060) begin err++; $display("FAIL single_ivec: got %o want 060", ivec_a); end
        chk++; if (dack_a !== 8'h08) begin err++; $display("FAIL single_dack: got %b want 00001000", dack_a); end
        chk++; if (irqo_a !== 1'b0) begin err++; $display("FAIL single_irq_ack: got %b want 0", irqo_a); end
        irq_a = 8'h00;
        tick();
        chk++; if (dack_a !== 8'h00) begin err++; $display("FAIL single_dack_pulse: got %b want 0", dack_a); end
        chk++; if ({iack_a, ivec_a} !== {1'b1, 9'o060}) begin err++; $display("FAIL single_release: got %b/%o want 1/060", iack_a, ivec_a); end
        istb_a = 1'b0;
        tick();
        chk++; if ({iack_a, ivec_a, busy_a} !== 11'd0) begin err++; $display("FAIL single_drop: got %b/%o/%b want 0/0/0", iack_a, ivec_a, busy_a); end
    endtask

    task automatic test_fixed();
        logic [8:0] ev [3];
        int         ei [3];
        bit         got;
        logic [8:0] v;
        logic [7:0] d;
        ev = '{9'o070, 9'o120, 9'o200};
        ei = '{2, 4, 7};
        for (int r = 0; r < 3; r++) set_vec(0, ei[r], ev[r]);
        irq_a = 8'b1001_0100;
        for (int r = 0; r < 3; r++) begin
            serve(0, 1, 1, got, v, d);
            chk++; if (!got) begin err++; $display("FAIL fixed_timeout: round %0d got no irq want irq", r); end
            chk++; if (v !== ev[r]) begin err++; $display("FAIL fixed_vec: round %0d got %o want %o", r, v, ev[r]); end
            chk++; if (d !== 8'(1 << ei[r])) begin err++; $display("FAIL fixed_dack: round %0d got %b want %b", r, d, 8'(1 << ei[r])); end
        end
        tick(); tick();
        chk++; if (irqo_a !== 1'b0) begin err++; $display("FAIL fixed_drained: got %b want 0", irqo_a); end
    endtask

    task automatic test_round_robin();
        int         seq [6];
        bit         got;
        logic [8:0] v;
        logic [7:0] d;
        logic [8:0] want;
        seq = '{1, 5, 1, 5, 7, 0};
        set_vec(1, 1, 9'o300); set_vec(1, 5, 9'o340);
        set_vec(1, 7, 9'o210); set_vec(1, 0, 9'o017);
        irq_b = 8'b0010_0010;
        for (int r = 0; r < 6; r++) begin
            if (r == 4) irq_b = 8'b1000_0001;
            serve(1, 0, (r >= 4), got, v, d);
            want = vec_b[9*seq[r] +: 9] & 9'o774;
            chk++; if (d !== 8'(1 << seq[r])) begin err++; $display("FAIL rr_grant: round %0d got %b want %b", r, d, 8'(1 << seq[r])); end
            chk++; if (v !== want) begin err++; $display("FAIL rr_vec: round %0d got %o want %o", r, v, want); end
        end
        irq_b = '0;
        rr_model = 1;
        tick(); tick();
    endtask

    task automatic test_withdraw();
        irq_a = 8'h20;
        tick();
        chk++; if (irqo_a !== 1'b1) begin err++; $display("FAIL wd_rise: got %b want 1", irqo_a); end
        tick();
        chk++; if (irqo_a !== 1'b1) begin err++; $display("FAIL wd_hold: got %b want 1", irqo_a); end
        irq_a = 8'h00;
        tick();
        chk++; if (irqo_a !== 1'b0) begin err++; $display("FAIL wd_fall: got %b want 0", irqo_a); end
        chk++; if ({iack_a, dack_a} !== 9'd0) begin err++; $display("FAIL wd_noack: got %b/%b want 0/0", iack_a, dack_a); end
        irq_a = 8'h40;
        tick();
        istb_a = 1'b1;
        irq_a = 8'h00;
        tick();
        chk++; if ({iack_a, irqo_a, busy_a, dack_a} !== 11'd0) begin err++; $display("FAIL wd_same_cycle: got %b/%b/%b/%b want 0", iack_a, irqo_a, busy_a, dack_a); end
        istb_a = 1'b0;
        tick();
    endtask

    task automatic test_capture();
        set_vec(0, 0, 9'o063);
        irq_a = 8'h01;
        tick();
        istb_a = 1'b1;
        tick();
        chk++; if (ivec_a !== 9'o060) begin err++; $display("FAIL cap_ack: got %o want 060", ivec_a); end
        irq_a = 8'h00;
        set_vec(0, 0, 9'o100);
        tick();
        chk++; if (ivec_a !== 9'o060) begin err++; $display("FAIL cap_release: got %o want 060", ivec_a); end
        tick();
        chk++; if ({iack_a, ivec_a} !== {1'b1, 9'o060}) begin err++; $display("FAIL cap_hold: got %b/%o want 1/060", iack_a, ivec_a); end
        istb_a = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [8:0] mv [8];
        logic [7:0] mreq;
        logic [7:0] nb;
        logic [7:0] d;
        logic [8:0] v;
        bit         got;
        int         w;
        for (int ub = 0; ub < 2; ub++) begin
            for (int rnd = 0; rnd < 20; rnd++) begin
                for (int i = 0; i < 8; i++) begin
                    mv[i] = 9'($urandom_range(0, 511));
                    set_vec(ub[0], i, mv[i]);
                end
                mreq = 8'($urandom_range(1, 255));
                if (ub == 1) irq_b = mreq; else irq_a = mreq;
                for (int it = 0; it < 40 && mreq != 8'd0; it++) begin
                    w = model_win(mreq, (ub == 1) ? rr_model : 0);
                    serve(ub[0], $urandom_range(0, 3), 1, got, v, d);
                    chk++; if (!got) begin err++; $display("FAIL rand_timeout: dut %0d got no irq want irq", ub); break; end
                    chk++; if (d !== 8'(1 << w)) begin err++; $display("FAIL rand_grant: dut %0d req %b got %b want %b", ub, mreq, d, 8'(1 << w)); end
                    chk++; if (v !== (mv[w] & 9'o774)) begin err++; $display("FAIL rand_vec: dut %0d got %o want %o", ub, v, mv[w] & 9'o774); end
                    mreq[w] = 1'b0;
                    if (ub == 1) rr_model = (w + 1) % 8;
                    if ($urandom_range(0, 3) == 0) begin
                        nb = 8'($urandom_range(0, 255));
                        mreq = mreq | nb;
                        if (ub == 1) irq_b = irq_b | nb; else irq_a = irq_a | nb;
                    end
                end
                irq_a = '0; irq_b = '0;
                tick(); tick();
            end
        end
    endtask

    task automatic test_reset_midack();
        bit         got;
        logic [8:0] v;
        logic [7:0] d;
        set_vec(0, 2, 9'o244);
        irq_a = 8'h04;
        tick();
        istb_a = 1'b1;
        tick(); tick();
        chk++; if (iack_a !== 1'b1) begin err++; $display("FAIL rma_pre: got %b want 1", iack_a); end
        #2 rst = 1'b1;
        #1;
        chk++; if ({iack_a, ivec_a, irqo_a, busy_a} !== 12'd0) begin err++; $display("FAIL rma_async: got %b/%o/%b/%b want 0", iack_a, ivec_a, irqo_a, busy_a); end
        #2 rst = 1'b0;
        rr_model = 0;
        tick();
        chk++; if (irqo_a !== 1'b0) begin err++; $display("FAIL rma_edge1: got %b want 0", irqo_a); end
        istb_a = 1'b0;
        tick();
        chk++; if (irqo_a !== 1'b1) begin err++; $display("FAIL rma_edge2: got %b want 1", irqo_a); end
        serve(0, 0, 1, got, v, d);
        chk++; if (v !== 9'o244) begin err++; $display("FAIL rma_reserve: got %o want 244", v); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fixed();
        test_round_robin();
        test_withdraw();
        test_capture();
        test_random();
        test_reset_midack();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
